// File: rtl/iir_pkg.sv
// Shared definitions for the multi-channel IIR core.
//   state_t        : FSM state encoding (S_IDLE, S_MAC, S_WRITE)
//   IIR_BITS       : default coefficient fractional bits
//   IIR_X_COEFFS   : default feed-forward coefficients, index 0 = newest sample
//   IIR_Y_COEFFS   : default feedback coefficients, index 0 unused
//   deq()          : divide a product by 2^bits, truncating toward zero
package iir_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WRITE
  } state_t;

  localparam int IIR_BITS = 10;

  localparam logic [31:0] IIR_X_COEFFS [2] = '{32'h000000B2, 32'h000000B2};
  localparam logic [31:0] IIR_Y_COEFFS [2] = '{32'h00000000, 32'hFFFFFD66};

  // Truncation toward zero, not floor: negative products get a bias of
  // 2^bits-1 before the arithmetic shift so that -115.77 becomes -115.
  // Works on a 128-bit container so any DATA_WIDTH up to 64 fits.
  function automatic logic signed [127:0] deq(input logic signed [127:0] p,
                                             input int bits);
    logic signed [127:0] bias;
    bias = p[127] ? ((128'sd1 <<< bits) - 128'sd1) : 128'sd0;
    return (p + bias) >>> bits;
  endfunction

endpackage

// File: rtl/iir_mc.sv
// Multi-channel, parametrised-order fixed-point IIR filter core.
// Samples for NUM_CH channels arrive interleaved; each channel keeps its own
// x/y history. One tap is evaluated per cycle with a single multiplier pair,
// and only every DECIM-th frame (one sample per channel) is written out.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   din          : input sample, valid when in_empty=0 (FWFT FIFO)
//   in_empty     : input FIFO empty
//   in_rd_en     : pops the input FIFO (combinational, S_IDLE only)
//   dout         : filtered sample, registered
//   out_full     : output FIFO full
//   out_wr_en    : pushes dout (combinational, S_WRITE only)
module iir_mc
  import iir_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_TAPS   = 2,
  parameter int NUM_CH     = 2,
  parameter int DECIM      = 1,
  parameter int BITS       = IIR_BITS,
  parameter logic [DATA_WIDTH-1:0] X_COEFFS [NUM_TAPS] = IIR_X_COEFFS,
  parameter logic [DATA_WIDTH-1:0] Y_COEFFS [NUM_TAPS] = IIR_Y_COEFFS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  out_full,
  output logic                  out_wr_en
);

  localparam int PW    = 2 * DATA_WIDTH;
  localparam int TAP_W = $clog2(NUM_TAPS);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_x_hist [NUM_CH][NUM_TAPS];
  // y history slot i holds the output i samples back; slot 0 is never
  // read because the feedback sum starts at tap 1.
  logic [DATA_WIDTH-1:0] r_y_hist [NUM_CH][NUM_TAPS];
  logic [CH_W-1:0]       r_ch;
  logic [DC_W-1:0]       r_dc;
  logic [TAP_W-1:0]      r_tap;
  logic [DATA_WIDTH-1:0] r_acc;

  logic signed [PW-1:0]  w_xprod, w_yprod;
  logic [DATA_WIDTH-1:0] w_xterm, w_yterm, w_acc_next;
  logic                  w_emit;

  assign w_xprod = PW'($signed(X_COEFFS[r_tap])) * PW'($signed(r_x_hist[r_ch][r_tap]));
  assign w_yprod = PW'($signed(Y_COEFFS[r_tap])) * PW'($signed(r_y_hist[r_ch][r_tap]));

  assign w_xterm    = DATA_WIDTH'(deq(128'(w_xprod), BITS));
  assign w_yterm    = (r_tap != '0) ? DATA_WIDTH'(deq(128'(w_yprod), BITS)) : '0;
  assign w_acc_next = r_acc + w_xterm + w_yterm;

  assign w_emit    = (r_dc == '0);
  assign in_rd_en  = (r_state == S_IDLE) && !in_empty;
  assign out_wr_en = (r_state == S_WRITE) && w_emit && !out_full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_x_hist <= '{default: '0};
      r_y_hist <= '{default: '0};
      r_ch     <= '0;
      r_dc     <= '0;
      r_tap    <= '0;
      r_acc    <= '0;
      dout     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!in_empty) begin
            for (int i = NUM_TAPS - 1; i > 0; i--)
              r_x_hist[r_ch][i] <= r_x_hist[r_ch][i-1];
            r_x_hist[r_ch][0] <= din;
            r_acc   <= '0;
            r_tap   <= '0;
            r_state <= S_MAC;
          end
        end

        S_MAC: begin
          r_acc <= w_acc_next;
          if (r_tap == TAP_W'(NUM_TAPS - 1)) begin
            // Result is committed on the way into S_WRITE, so a stall there
            // can never update history or dout twice.
            for (int i = NUM_TAPS - 1; i > 1; i--)
              r_y_hist[r_ch][i] <= r_y_hist[r_ch][i-1];
            r_y_hist[r_ch][1] <= w_acc_next;
            dout    <= w_acc_next;
            r_state <= S_WRITE;
          end else begin
            r_tap <= r_tap + 1'b1;
          end
        end

        S_WRITE: begin
          // Non-emit frames leave immediately; emit frames wait for room.
          if (!w_emit || !out_full) begin
            if (r_ch == CH_W'(NUM_CH - 1)) begin
              r_ch <= '0;
              r_dc <= (r_dc == DC_W'(DECIM - 1)) ? '0 : r_dc + 1'b1;
            end else begin
              r_ch <= r_ch + 1'b1;
            end
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/iir_mc.md
# iir_mc

Multi-channel, parametrised-order fixed-point IIR filter core for the FM radio pipeline. It generalises the single-channel de-emphasis IIR in three ways: interleaved channels with independent history (stereo L/R), any tap count, and optional output decimation. It sits between an input FIFO and an output FIFO, both owned by the `iir_mc_top` wrapper. The core talks to them through the standard first-word-fall-through FIFO ports.

## Interface
- DATA_WIDTH, 32: sample and coefficient width, signed two's complement.
- NUM_TAPS, 2: filter order + 1; must be ≥ 2.
- NUM_CH, 2: number of interleaved channels; samples arrive ch0, ch1, …, ch(NUM_CH-1), ch0, …
- DECIM, 1: output decimation factor; must be ≥ 1.
- BITS, 10: fractional bits of the coefficients (quantisation shift).
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- din  in  DATA_WIDTH  input sample; valid whenever in_empty=0.
- in_empty  in  1  input FIFO empty.
- in_rd_en  out  1  pops the input FIFO; combinational, asserted only in S_IDLE when in_empty=0.
- dout  out  DATA_WIDTH  filtered sample; registered.
- out_full  in  1  output FIFO full.
- out_wr_en  out  1  pushes dout; combinational, asserted only in S_WRITE when out_full=0.

## Operation
- Per-channel state: x_hist[NUM_CH][NUM_TAPS] and y_hist[NUM_CH][NUM_TAPS], both DATA_WIDTH.
- Counters: ch_idx (0..NUM_CH-1) and decim_cnt (0..DECIM-1). decim_cnt advances when ch_idx wraps.
- Filter equation for the current channel c, where x[0] is the newest sample:
  - y = Σ_{i=0..T-1} DEQ(X_COEFFS[i]·x[i]) + Σ_{i=1..T-1} DEQ(Y_COEFFS[i]·y[i]).
  - Y_COEFFS[0] is unused.
- DEQ(p) = p / 2^BITS, truncated toward zero. It is not an arithmetic shift: −115.77 → −115.
- Each product is 2·DATA_WIDTH bits; DEQ result is cast back to DATA_WIDTH.
- Accumulation wraps modulo 2^DATA_WIDTH.
- FSM states:
  - S_IDLE: when in_empty=0, assert in_rd_en. Shift din into x_hist[c], clear acc, tap=0, go to S_MAC. Otherwise stay.
  - S_MAC: one tap per cycle, acc += DEQ(X[tap]·x_hist[c][tap]) + (tap>0 ? DEQ(Y[tap]·y_hist[c][tap]) : 0). After tap=NUM_TAPS-1, go to S_WRITE.
  - S_WRITE, entry cycle: shift acc into y_hist[c] and load dout=acc. This happens once, even during a stall.
  - S_WRITE, emit frame (decim_cnt==0): wait for out_full=0, assert out_wr_en, then advance counters and go to S_IDLE.
  - S_WRITE, non-emit frame: no write; advance counters and go to S_IDLE in the same cycle.
- History is updated for every sample; decimation only suppresses writes.
- NUM_CH=1, DECIM=1 is bit-exact with the existing single-channel de-emphasis IIR.

## Timing
- Reset values: state=S_IDLE, dout=0, all histories 0, ch_idx=0, decim_cnt=0, acc=0. in_rd_en and out_wr_en are 0 (state-decoded).
- Throughput: NUM_TAPS+2 cycles per sample without stalls.
- Latency: NUM_TAPS+1 cycles from the in_rd_en cycle to the out_wr_en cycle.
- Back-pressure: out_full=1 in S_WRITE holds the FSM. No input is popped and dout is stable.
- in_empty=1 in S_IDLE idles the core indefinitely with no state change.
- Reset mid-operation: the in-flight sample is discarded, histories are cleared, and channel alignment restarts at ch0.

## Structure
- Package iir_pkg holds:
  - the state enum;
  - DEQ as a function;
  - default coefficient arrays IIR_X_COEFFS = {32'h000000B2, 32'h000000B2} and IIR_Y_COEFFS = {32'h00000000, 32'hFFFFFD66};
  - the BITS default.
- No sub-module in the core: one multiplier pair plus the FSM.
- The `iir_mc_top` wrapper instantiates the existing fifo module on input and output.

## Test plan
- Impulse test (NUM_CH=1, DECIM=1, default coefficients):
  - Input 1024, 0, 0.
  - Required outputs: 178, then 178 + DEQ(−666·178) = 63, then DEQ(−666·63) = −40.
- Channel independence (NUM_CH=2):
  - Input ch0 = 1024, 0, 0 interleaved with ch1 = 0, 0, 0.
  - Required outputs: 178, 0, 63, 0, −40, 0.
- Decimation (DECIM=2, NUM_CH=1):
  - Input 1024, 0, 0, 0.
  - Exactly 2 writes: 178 and −40.
  - Histories still advanced on the unwritten samples.
- Back-pressure:
  - Hold out_full=1 for 5 cycles while in S_WRITE.
  - out_wr_en stays 0, in_rd_en stays 0, dout is stable.
  - The write completes in the first cycle after out_full drops.
- Reset mid-operation:
  - Assert reset during S_MAC of the 2nd sample, then replay the impulse.
  - Outputs match the fresh-impulse sequence.
- Regression: run the 100-sample left_channel.txt stream through `iir_mc_top` (NUM_CH=1) against left_deemph.txt with 0 errors.
